serial_addsub_ctrl: RTL and testbench

Bit-serial add/subtract sequencer for the execution-unit ALU. It reuses one 1-bit full adder cell (ADD1b) across WIDTH clock cycles, LSB first, instead of a WIDTH-bit ripple adder. It latches operands on a start/busy/done handshake and drives the adder inputs and carry register each cycle. It returns the result with carry, overflow and zero flags.

---
 rtl/serial_addsub_ctrl.sv | 140 ++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract sequencer.
// A single 1-bit full adder is reused for WIDTH cycles, LSB first. Operands
// are latched on start; result and flags are published with a one-cycle done.
module serial_addsub_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d;
   logic             c_q, c_d;
   logic             c_msb_q, c_msb_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic             fa_a, fa_b, fa_s, fa_co;
   logic             last_bit, accept;
   logic [WIDTH-1:0] res_done;

   // ADD1b cell: subtract inverts b; the +1 comes from the preset carry.
   assign fa_a  = a_sh_q[0];
   assign fa_b  = b_sh_q[0] ^ op_q;
   assign fa_s  = fa_a ^ fa_b ^ c_q;
   assign fa_co = (fa_a & fa_b) | (c_q & (fa_a ^ fa_b));

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
   // DONE accepts a new start just like IDLE, allowing back-to-back ops.
   assign accept   = start && (state_q != S_RUN);
   assign res_done = {fa_s, res_sh_q[WIDTH-1:1]};

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         c_q      <= 1'b0;
         c_msb_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         c_q      <= c_d;
         c_msb_q  <= c_msb_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_bit) state_d = S_DONE;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: load on accept, shift one bit per RUN cycle, publish on last bit.
   always_comb begin
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      c_d      = c_q;
      c_msb_d  = c_msb_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      if (accept) begin
         a_sh_d = a;
         b_sh_d = b;
         op_d   = op;
         c_d    = op;
         cnt_d  = '0;
      end else if (state_q == S_RUN) begin
         a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
         b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
         res_sh_d = res_done;
         c_d      = fa_co;
         cnt_d    = cnt_q + CNT_W'(1);
         // Carry entering the MSB is the carry produced by bit WIDTH-2.
         if (cnt_q == CNT_W'(WIDTH - 2)) c_msb_d = fa_co;
         if (last_bit) begin
            result_d = res_done;
            cout_d   = fa_co;
            ovf_d    = c_msb_q ^ fa_co;
            zero_d   = (res_done == '0);
         end
      end
   end

   // Outputs.
   always_comb begin
      busy     = (state_q == S_RUN);
      done     = (state_q == S_DONE);
      result   = result_q;
      cout     = cout_q;
      overflow = ovf_q;
      zero     = zero_q;
   end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized self-checking bench for serial_addsub_ctrl (WIDTH=8).
module tb_serial_addsub_ctrl;
   logic       clk = 1'b0;
   logic       rst, start, op;
   logic [7:0] a, b, result;
   logic       busy, done, cout, overflow, zero;
   int         n_chk = 0;
   int         n_err = 0;

   serial_addsub_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .cout(cout),
      .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: integer arithmetic. Returns {zero, overflow, cout, result}.
   function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic o);
      int ua, ub, sa, sb, u, s;
      logic [7:0] r;
      logic c, v;
      ua = x; ub = y;
      sa = $signed(x); sb = $signed(y);
      u = o ? ua - ub : ua + ub;
      s = o ? sa - sb : sa + sb;
      r = u[7:0];
      c = o ? (ua >= ub) : (u > 255);
      v = (s < -128) || (s > 127);
      return {(r == 8'h00), v, c, r};
   endfunction

   task automatic chk_flags(input string tag, input logic [10:0] e);
      chk({tag, "_res"}, result, e[7:0]);
      chk({tag, "_cout"}, cout, e[8]);
      chk({tag, "_ovf"}, overflow, e[9]);
      chk({tag, "_zero"}, zero, e[10]);
   endtask

   // One operation from IDLE; optional spurious start at RUN cycle spur_at.
   task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic o,
                         input int spur_at, input string tag);
      logic [10:0] e;
      int n;
      bit early;
      e = model(x, y, o);
      start = 1'b1; a = x; b = y; op = o;
      @(posedge clk); #1;
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
      chk({tag, "_busy"}, busy, 1'b1);
      n = 0;
      early = 1'b0;
      while (!done && n < 20) begin
         start = (n + 1 == spur_at);
         if (start) begin a = 8'hAA; b = 8'h55; end
         @(posedge clk); #1;
         n++;
         if (!done && !busy) early = 1'b1;
      end
      start = 1'b0;
      chk({tag, "_lat"}, n, 8);
      chk({tag, "_early_idle"}, early, 1'b0);
      chk({tag, "_busy_at_done"}, busy, 1'b0);
      chk_flags(tag, e);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, done, 1'b0);
      chk({tag, "_hold"}, result, e[7:0]);
   endtask

   initial begin
      logic [10:0] e1, e2;
      int n;
      bit seen;
      rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_out", {result, cout, overflow, zero}, 11'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      run_op(8'h05, 8'h03, 1'b0, 0, "add");
      run_op(8'hFF, 8'h01, 1'b0, 0, "add_wrap");
      run_op(8'h7F, 8'h01, 1'b0, 0, "add_ovf");
      run_op(8'h10, 8'h20, 1'b1, 0, "sub_borrow");
      run_op(8'h80, 8'h01, 1'b1, 0, "sub_ovf");
      run_op(8'h05, 8'h03, 1'b0, 3, "start_in_run");

      // Back-to-back: start stays high; second op accepted on the DONE-cycle edge,
      // and its done arrives 8 cycles after that accepting edge.
      e1 = model(8'h12, 8'h34, 1'b0);
      e2 = model(8'h9C, 8'h27, 1'b1);
      start = 1'b1; a = 8'h12; b = 8'h34; op = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while (!done && n < 20) begin @(posedge clk); #1; n++; end
      chk("b2b_lat1", n, 8);
      chk_flags("b2b_1", e1);
      a = 8'h9C; b = 8'h27; op = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_accept", {busy, done}, 2'b10);
      n = 0;
      while (!done && n < 20) begin @(posedge clk); #1; n++; end
      chk("b2b_lat2", n, 8);
      chk_flags("b2b_2", e2);
      @(posedge clk); #1;

      // Reset mid-operation aborts with no done pulse
      start = 1'b1; a = 8'h05; b = 8'h03; op = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy_done", {busy, done}, 2'b00);
      chk("abort_out", {result, cout, overflow, zero}, 11'h0);
      seen = 1'b0;
      repeat (12) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
      chk("abort_no_done", seen, 1'b0);
      run_op(8'h01, 8'h01, 1'b0, 0, "after_abort");

      // rst and start together: rst wins
      rst = 1'b1; start = 1'b1; a = 8'h33; b = 8'h44;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy", busy, 1'b0);
      chk("rst_start_out", result, 8'h00);

      // Randomized operations with idle gaps
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         run_op(8'($urandom), 8'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0, "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
